exec_muldiv_unit: RTL
=====================

// Module: exec_muldiv_unit
// PURPOSE
//  Iterative RV32M/RV64M multiply/divide unit beside the execute-stage ALU of the three-stage core.
//  Accepts one M-extension op per request and runs an N = XLEN/UNROLL step radix-2 shift-add or restoring-divide loop.
//  Returns a registered result plus destination tag; the execute stage stalls on !resp_valid.
//  Generalises the single-cycle execute datapath: XLEN-wide, configurable bits-per-cycle, abortable by branch flush.
// PARAMETERS
//  XLEN    32  operand/result width; 32 or 64
//  UNROLL  1   radix-2 steps per clock; 1, 2 or 4; must divide XLEN
// PORTS
//  clk          in   1     clock
//  reset        in   1     asynchronous, active-low reset
//  flush        in   1     kill in-flight op (taken branch / jump redirect)
//  req_valid    in   1     request present; held with operands stable until resp_valid
//  req_ready    out  1     unit idle (state==IDLE)
//  req_op       in   3     funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111
//  req_rs1      in   XLEN  operand 1 (dividend / multiplicand)
//  req_rs2      in   XLEN  operand 2 (divisor / multiplier)
//  req_rd       in   5     destination register tag, passed through
//  resp_valid   out  1     one-cycle result pulse
//  resp_result  out  XLEN  result, registered
//  resp_rd      out  5     tag of completed op
//  busy         out  1     state is RUN or DONE
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, step count=0, resp_result=0, resp_rd=0, resp_valid=0, busy=0, req_ready=1.
//  - States:
//    - IDLE->RUN on req_valid && !flush; operands, op and tag are captured.
//    - IDLE->DONE directly on the special cases below.
//    - RUN->DONE after N steps.
//    - DONE->IDLE unconditionally.
//  - Capture cycle is cycle 0. The normal path has resp_valid high in cycle N+1 only; the special path has it in cycle 1 only.
//  - Signed ops:
//    - MULH: both operands are made absolute at capture.
//    - MULHSU: only rs1 is made absolute.
//    - DIV/REM: both operands are made absolute at capture.
//    - The result sign is stored and negation is applied on the final RUN edge, so resp_result is always a register output.
//  - Multiply: 2*XLEN product accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//  - Divide: restoring, one quotient bit per step, XLEN+1 bit partial remainder. Sign rules:
//    - quotient negated iff the operand signs differ;
//    - remainder takes the dividend sign.
//  - Special cases (single cycle, no RUN):
//    - divide by zero: DIV/DIVU = all ones; REM/REMU = rs1.
//    - signed overflow (rs1 = MIN_INT, rs2 = -1): DIV = MIN_INT; REM = 0.
//  - Flush:
//    - In RUN or DONE: the next state is IDLE and no resp_valid is produced for the killed op.
//    - Flush in the same cycle as resp_valid does not retract the current pulse; the pipeline discards it.
//    - Flush with req_valid in IDLE: flush wins and nothing is captured.
//  - Back-to-back: a new capture is legal in the cycle after resp_valid. No overlap; req_ready=0 in RUN and DONE.
//  - resp_result and resp_rd hold their last value outside resp_valid.
//  - Reset mid-operation: immediate return to IDLE with reset values, no response.
//  - Step counter is clog2(N)+1 bits and must not wrap inside one op.
// STRUCTURE
//  - Shared package muldiv_pkg:
//    - funct3 localparams (MUL..REMU);
//    - state enum {IDLE, RUN, DONE};
//    - function is_signed_op(op).
//  - Sub-module muldiv_step: combinational single radix-2 step (add-shift or compare-subtract-shift), instantiated UNROLL times in a chain.
//  - Top level holds the FSM, counter, operand, sign and result registers.
// TESTING
//  - MUL 7 * 0xFFFFFFFD (XLEN=32, UNROLL=1) -> resp_result 0xFFFFFFEB, resp_valid only in cycle 33, resp_rd echoes req_rd.
//  - MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/2 -> 3; REMU 7/2 -> 1.
//  - Special cases, each with resp_valid in cycle 1:
//    - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5;
//    - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//  - Flush of a DIV in cycle 10 -> no resp_valid, req_ready=1 in cycle 11; req_valid+flush in IDLE -> no capture.
//  - UNROLL=2 MUL 3*5 -> 15 in cycle 17; reset asserted in cycle 5 of RUN -> outputs at reset values, next request completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension unit.
// funct3 encodings, FSM states and op classification.
package muldiv_pkg;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic is_signed_op(
    input logic [2:0] op
  );
    return (op == MULH) || (op == MULHSU) ||
           (op == DIV)  || (op == REM);
  endfunction

endpackage

// File: rtl/exec_muldiv_unit_if.sv
// Request/response bundle between execute stage and muldiv unit.
// master = execute stage, slave = muldiv unit.
interface exec_muldiv_unit_if #(
    parameter int XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [4:0]      req_rd;
    logic            resp_valid;
    logic [XLEN-1:0] resp_result;
    logic [4:0]      resp_rd;

    modport master (
        output req_valid, req_op,
        output req_rs1, req_rs2, req_rd,
        input  req_ready, resp_valid,
        input  resp_result, resp_rd
    );

    modport slave (
        input  req_valid, req_op,
        input  req_rs1, req_rs2, req_rd,
        output req_ready, resp_valid,
        output resp_result, resp_rd
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 step: shift-add multiply or restoring divide.
// acc is {hi, lo}; lo holds multiplier bits or dividend/quotient.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div,
    input  logic [XLEN-1:0]   b,
    input  logic [2*XLEN-1:0] acc_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rs;
    logic          ge;

    always_comb begin
        sum = {1'b0, acc_i[2*XLEN-1:XLEN]} +
              (acc_i[0] ? {1'b0, b} : '0);
        rs  = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        ge  = rs >= {1'b0, b};
        if (div) begin
            acc_o = {ge ? XLEN'(rs - {1'b0, b})
                        : rs[XLEN-1:0],
                     acc_i[XLEN-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit beside the execute ALU.
// UNROLL radix-2 steps per clock, abortable by flush.
module exec_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    output logic busy,
    exec_muldiv_unit_if.slave io
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N) + 1;
    localparam logic [XLEN-1:0] MIN_INT =
        {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;

    state_e state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [2:0]        op;
    logic              neg;
    logic [4:0]        rd;

    logic              start, last;
    logic              div0, ovf, special;
    logic              s1, s2, neg_c, mul_c;
    logic [XLEN-1:0]   a1, b2, spec_res;

    logic [UNROLL:0][2*XLEN-1:0] chain;
    logic [2*XLEN-1:0] fin, p;
    logic [XLEN-1:0]   q, r, res;

    assign start = io.req_valid && !flush;
    assign last  = cnt == CW'(N - 1);

    // Capture-time operand conditioning and special-case detection
    always_comb begin
        mul_c = !io.req_op[2];
        s1 = is_signed_op(io.req_op) &&
             io.req_rs1[XLEN-1];
        s2 = is_signed_op(io.req_op) &&
             (io.req_op != MULHSU) &&
             io.req_rs2[XLEN-1];
        neg_c = (io.req_op == REM) ? s1 : (s1 ^ s2);
        a1 = s1 ? -io.req_rs1 : io.req_rs1;
        b2 = s2 ? -io.req_rs2 : io.req_rs2;
        div0 = io.req_op[2] && (io.req_rs2 == '0);
        ovf = ((io.req_op == DIV) || (io.req_op == REM)) &&
              (io.req_rs1 == MIN_INT) &&
              (io.req_rs2 == ONES);
        special = div0 || ovf;
        if (div0) begin
            spec_res = io.req_op[1] ? io.req_rs1 : ONES;
        end else begin
            spec_res = io.req_op[1] ? '0 : MIN_INT;
        end
    end

    assign chain[0] = acc;
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        muldiv_step #(
            .XLEN (XLEN)
        ) u_step (
            .div   (op[2]),
            .b     (opb),
            .acc_i (chain[i]),
            .acc_o (chain[i+1])
        );
    end
    assign fin = chain[UNROLL];

    // Sign fix-up on the final step's value
    always_comb begin
        p   = neg ? -fin : fin;
        q   = fin[XLEN-1:0];
        r   = fin[2*XLEN-1:XLEN];
        res = p[XLEN-1:0];
        unique case (1'b1)
            op == MUL:
                res = p[XLEN-1:0];
            !op[2] && (op[1:0] != 2'b00):
                res = p[2*XLEN-1:XLEN];
            op[2] && !op[1]:
                res = neg ? -q : q;
            op[2] && op[1]:
                res = neg ? -r : r;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = special ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io.req_ready  = state == IDLE;
        io.resp_valid = state == DONE;
        busy          = state != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            acc            <= '0;
            opb            <= '0;
            op             <= MUL;
            neg            <= 1'b0;
            rd             <= '0;
            io.resp_result <= '0;
            io.resp_rd     <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (start) begin
                op  <= io.req_op;
                rd  <= io.req_rd;
                neg <= neg_c;
                acc <= {{XLEN{1'b0}}, mul_c ? b2 : a1};
                opb <= mul_c ? a1 : b2;
                if (special) begin
                    io.resp_result <= spec_res;
                    io.resp_rd     <= io.req_rd;
                end
            end
        end else if (state == RUN) begin
            acc <= fin;
            cnt <= cnt + 1'b1;
            if (last && !flush) begin
                io.resp_result <= res;
                io.resp_rd     <= rd;
            end
        end
    end

endmodule
